// File: rtl/piso_pkg.sv
`default_nettype none
// ============================================================================
// Module  : piso_pkg
// Brief   : Shared FSM state type and counter-width helper for piso_serializer.
// Revision: 1.0
// ============================================================================
package piso_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

   // Bits needed to hold 0..max_val, never less than one so zero-length counters stay legal.
   function automatic int cnt_width(input int max_val);
      int w;
      w = $clog2(max_val + 1);
      return (w < 1) ? 1 : w;
   endfunction

   localparam int c_DEF_WIDTH    = 5;
   localparam int c_DEF_DIV      = 1;
   localparam int c_DEF_GAP_BITS = 0;

endpackage
`default_nettype wire

// File: rtl/piso_serializer_if.sv
`default_nettype none
// ============================================================================
// Module  : piso_serializer_if
// Brief   : Parallel word handshake plus serial output bundle.
// Revision: 1.0
// ============================================================================
interface piso_serializer_if #(
   parameter int WIDTH = 5
);
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_ready;
   logic             so;
   logic             so_valid;
   logic             busy;
   logic             done;

   modport master (
      output din, din_valid,
      input  din_ready, so, so_valid, busy, done
   );

   modport slave (
      input  din, din_valid,
      output din_ready, so, so_valid, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/piso_serializer_bit_tick_gen.sv
`default_nettype none
// ============================================================================
// Module  : bit_tick_gen
// Brief   : Bit-time divider; ticks on the last clock of every DIV-clock bit.
// Revision: 1.0
// ============================================================================
module bit_tick_gen
   import piso_pkg::*;
#(
   parameter int DIV = 1
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic i_en,
   input  wire logic i_clr,
   output logic      o_tick
);
   localparam int             c_W    = cnt_width(DIV);
   localparam logic [c_W-1:0] c_LAST = c_W'(DIV - 1);

   logic [c_W-1:0] r_cnt;

   assign o_tick = i_en && (r_cnt == c_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr || o_tick) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + c_W'(1);
      end
   end
endmodule
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module  : piso_serializer
// Brief   : Parallel-in/serial-out stage with DIV-clock bit-times and idle gap.
// Revision: 1.0
// ============================================================================
module piso_serializer
   import piso_pkg::*;
#(
   parameter int WIDTH     = c_DEF_WIDTH,
   parameter int DIV       = c_DEF_DIV,
   parameter int LSB_FIRST = 1,
   parameter int GAP_BITS  = c_DEF_GAP_BITS
) (
   input wire logic          clk,
   input wire logic          rst,
   piso_serializer_if.slave  bus
);
   localparam int                 c_BIT_W    = $clog2(WIDTH);
   localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(WIDTH - 1);
   localparam int                 c_GAP_LEN  = GAP_BITS * DIV;
   localparam int                 c_GAP_W    = cnt_width(c_GAP_LEN);
   localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'((c_GAP_LEN > 0) ? c_GAP_LEN - 1 : 0);

   state_t             r_state;
   state_t             w_next;
   logic [WIDTH-1:0]   r_shreg;
   logic [c_BIT_W-1:0] r_bit_cnt;
   logic [c_GAP_W-1:0] r_gap_cnt;
   logic               r_so;

   logic             w_tick;
   logic             w_word_end;
   logic             w_ready;
   logic             w_accept;
   logic             w_gap_end;
   logic             w_first_bit;
   logic             w_next_bit;
   logic [WIDTH-1:0] w_shifted;

   bit_tick_gen #(.DIV(DIV)) u_tick (
      .clk    (clk),
      .rst    (rst),
      .i_en   (r_state == SHIFT),
      .i_clr  (r_state != SHIFT),
      .o_tick (w_tick)
   );

   generate
      if (LSB_FIRST != 0) begin : g_lsb
         assign w_first_bit = bus.din[0];
         assign w_next_bit  = r_shreg[1];
         assign w_shifted   = {1'b0, r_shreg[WIDTH-1:1]};
      end else begin : g_msb
         assign w_first_bit = bus.din[WIDTH-1];
         assign w_next_bit  = r_shreg[WIDTH-2];
         assign w_shifted   = {r_shreg[WIDTH-2:0], 1'b0};
      end
   endgenerate

   assign w_word_end = (r_state == SHIFT) && w_tick && (r_bit_cnt == c_BIT_LAST);
   // With no gap the last bit-time doubles as an accept slot so words stream without a bubble.
   assign w_ready    = (r_state == IDLE) || (w_word_end && (GAP_BITS == 0));
   assign w_accept   = bus.din_valid && w_ready;
   assign w_gap_end  = (r_state == GAP) && (r_gap_cnt == c_GAP_LAST);

   assign bus.din_ready = w_ready;
   assign bus.so        = r_so;
   assign bus.so_valid  = (r_state == SHIFT) && w_tick;
   assign bus.busy      = (r_state != IDLE);
   assign bus.done      = w_word_end;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) w_next = SHIFT;
         end
         SHIFT: begin
            if (w_word_end) begin
               if (GAP_BITS > 0)  w_next = GAP;
               else if (w_accept) w_next = SHIFT;
               else               w_next = IDLE;
            end
         end
         GAP: begin
            if (w_gap_end) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shreg   <= '0;
         r_bit_cnt <= '0;
         r_gap_cnt <= '0;
         r_so      <= 1'b0;
      end else begin
         if (w_accept) begin
            r_shreg   <= bus.din;
            r_so      <= w_first_bit;
            r_bit_cnt <= '0;
         end else if ((r_state == SHIFT) && w_tick) begin
            if (r_bit_cnt == c_BIT_LAST) begin
               r_bit_cnt <= '0;
               if (GAP_BITS > 0) r_so <= 1'b0;
            end else begin
               r_shreg   <= w_shifted;
               r_so      <= w_next_bit;
               r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
            end
         end

         if ((r_state == GAP) && !w_gap_end) begin
            r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
         end else begin
            r_gap_cnt <= '0;
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module  : tb_piso_serializer
// Brief   : Self-checking bench for three piso_serializer configurations.
// Revision: 1.0
// ============================================================================
module tb_piso_serializer;
   localparam int W = 5;
   localparam int DV [3] = '{1, 3, 2};
   localparam int LF [3] = '{1, 1, 0};
   localparam int GB [3] = '{0, 0, 2};

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   piso_serializer_if #(.WIDTH(W)) ifa ();
   piso_serializer_if #(.WIDTH(W)) ifb ();
   piso_serializer_if #(.WIDTH(W)) ifc ();

   piso_serializer #(.WIDTH(W), .DIV(1), .LSB_FIRST(1), .GAP_BITS(0)) u_a (.clk(clk), .rst(rst), .bus(ifa));
   piso_serializer #(.WIDTH(W), .DIV(3), .LSB_FIRST(1), .GAP_BITS(0)) u_b (.clk(clk), .rst(rst), .bus(ifb));
   piso_serializer #(.WIDTH(W), .DIV(2), .LSB_FIRST(0), .GAP_BITS(2)) u_c (.clk(clk), .rst(rst), .bus(ifc));

   logic [W-1:0] din [3];
   logic         dv  [3];
   assign ifa.din = din[0]; assign ifa.din_valid = dv[0];
   assign ifb.din = din[1]; assign ifb.din_valid = dv[1];
   assign ifc.din = din[2]; assign ifc.din_valid = dv[2];

   logic [W-1:0] q0 [$];
   logic [W-1:0] q1 [$];
   logic [W-1:0] q2 [$];

   int           nacc [3];
   logic [W-1:0] wd   [3];
   logic         erdy [3];
   int           t;
   int           errs   = 0;
   int           checks = 0;

   // Downstream 5-bit serial-in register fed by instance A.
   logic [W-1:0] sipo = '0;
   always @(posedge clk) if (ifa.so_valid) sipo <= {ifa.so, sipo[W-1:1]};

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s t=%0d: observed %b expected %b", tag, t, obs, exp);
      end
   endtask

   task automatic qpush(input int k, input logic [W-1:0] w);
      case (k)
         0: q0.push_back(w);
         1: q1.push_back(w);
         default: q2.push_back(w);
      endcase
   endtask

   function automatic int qsize(input int k);
      case (k)
         0: return q0.size();
         1: return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic logic [W-1:0] qfront(input int k);
      case (k)
         0: return q0[0];
         1: return q1[0];
         default: return q2[0];
      endcase
   endfunction

   task automatic qpop(input int k);
      case (k)
         0: void'(q0.pop_front());
         1: void'(q1.pop_front());
         default: void'(q2.pop_front());
      endcase
   endtask

   // Expected outputs at interval tt from the timing rules: word accepted at edge nacc
   // occupies W*DIV clocks, followed by GAP_BITS*DIV idle clocks.
   task automatic model(input int k, input int tt, output logic so, output logic sov,
                        output logic bsy, output logic dn, output logic rdy);
      int j, d, g, b, idx;
      d = DV[k]; g = GB[k];
      so = 1'b0; sov = 1'b0; bsy = 1'b0; dn = 1'b0; rdy = 1'b1;
      if (nacc[k] >= 0) begin
         j = tt - nacc[k];
         if (j < W * d) begin
            b   = j / d;
            idx = (LF[k] != 0) ? b : W - 1 - b;
            so  = wd[k][idx];
            sov = ((j % d) == d - 1);
            dn  = (j == W * d - 1);
            bsy = 1'b1;
            rdy = (g == 0) && dn;
         end else if (j < (W + g) * d) begin
            bsy = 1'b1;
            rdy = 1'b0;
         end else begin
            so = (g > 0) ? 1'b0 : wd[k][(LF[k] != 0) ? W - 1 : 0];
         end
      end
   endtask

   task automatic check_all(input string ph);
      logic so, sov, bsy, dn, rdy;
      for (int k = 0; k < 3; k++) begin
         model(k, t, so, sov, bsy, dn, rdy);
         erdy[k] = rdy;
         case (k)
            0: begin
               chk($sformatf("%s A.so", ph), ifa.so, so);       chk($sformatf("%s A.so_valid", ph), ifa.so_valid, sov);
               chk($sformatf("%s A.busy", ph), ifa.busy, bsy);  chk($sformatf("%s A.done", ph), ifa.done, dn);
               chk($sformatf("%s A.din_ready", ph), ifa.din_ready, rdy);
            end
            1: begin
               chk($sformatf("%s B.so", ph), ifb.so, so);       chk($sformatf("%s B.so_valid", ph), ifb.so_valid, sov);
               chk($sformatf("%s B.busy", ph), ifb.busy, bsy);  chk($sformatf("%s B.done", ph), ifb.done, dn);
               chk($sformatf("%s B.din_ready", ph), ifb.din_ready, rdy);
            end
            default: begin
               chk($sformatf("%s C.so", ph), ifc.so, so);       chk($sformatf("%s C.so_valid", ph), ifc.so_valid, sov);
               chk($sformatf("%s C.busy", ph), ifc.busy, bsy);  chk($sformatf("%s C.done", ph), ifc.done, dn);
               chk($sformatf("%s C.din_ready", ph), ifc.din_ready, rdy);
            end
         endcase
      end
   endtask

   initial begin
      logic sipo_pending;
      logic sipo_seen;
      sipo_pending = 1'b0;
      sipo_seen    = 1'b0;
      t = 0;
      for (int k = 0; k < 3; k++) begin
         nacc[k] = -1; wd[k] = '0; din[k] = '0; dv[k] = 1'b0; erdy[k] = 1'b1;
      end
      qpush(0, 5'b10110);
      qpush(1, 5'b00001);
      qpush(2, 5'b10011);
      qpush(2, 5'h1C);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all("reset");
      rst = 1'b0;

      for (int cyc = 0; cyc < 820; cyc++) begin
         if (cyc > 0) begin
            @(negedge clk);
            check_all("run");
         end
         if (rst) rst = 1'b0;

         if (sipo_pending) begin
            chk("sipo_after_first_word", sipo[0], 1'b0);
            chk("sipo_word", (sipo === 5'b10110), 1'b1);
            sipo_pending = 1'b0;
         end
         if (!sipo_seen && ifa.done === 1'b1 && nacc[0] >= 0 && wd[0] == 5'b10110) begin
            sipo_pending = 1'b1;
            sipo_seen    = 1'b1;
         end

         if (cyc == 40) begin
            qpush(0, 5'h15); qpush(0, 5'h0A);
            qpush(1, 5'($urandom)); qpush(2, 5'($urandom));
         end
         if (cyc >= 80 && cyc < 700) begin
            for (int k = 0; k < 3; k++)
               if (qsize(k) < 3 && $urandom_range(0, 5) == 0) qpush(k, 5'($urandom));
         end
         if (cyc == 770) qpush(0, 5'b11111);

         // Asynchronous reset mid-word on instance A.
         if (cyc == 774) begin
            #1 rst = 1'b1;
            #1;
            chk("async_rst A.so", ifa.so, 1'b0);
            chk("async_rst A.so_valid", ifa.so_valid, 1'b0);
            chk("async_rst A.busy", ifa.busy, 1'b0);
            chk("async_rst A.din_ready", ifa.din_ready, 1'b1);
            for (int k = 0; k < 3; k++) nacc[k] = -1;
         end

         for (int k = 0; k < 3; k++) begin
            if (qsize(k) > 0) begin
               din[k] = qfront(k);
               dv[k]  = (cyc < 80 || cyc >= 700) ? 1'b1 : ($urandom_range(0, 3) != 0);
            end else begin
               din[k] = 5'($urandom);
               dv[k]  = 1'b0;
            end
         end

         @(posedge clk);
         if (!rst) begin
            for (int k = 0; k < 3; k++) begin
               if (dv[k] && erdy[k]) begin
                  nacc[k] = t + 1;
                  wd[k]   = din[k];
                  qpop(k);
               end
            end
         end
         t++;
      end

      chk("sipo_checked", sipo_seen, 1'b1);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
`default_nettype wire
